// File: rtl/spmc_pwm_sequencer_pkg.sv
// Shared definitions for the spmc_pwm sequencer: register map, control bits,
// table entry layout, spmc_pwm register offsets and FSM encoding.
package spmc_pwm_sequencer_pkg;

    localparam int DATA_W = 18;
    localparam int ADDR_W = 10;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_TBL_IDX  = 3'd1;
    localparam logic [2:0] REG_TBL_DATA = 3'd2;
    localparam logic [2:0] REG_LEN      = 3'd3;
    localparam logic [2:0] REG_PRESC    = 3'd4;

    localparam int CTRL_START    = 0;
    localparam int CTRL_STOP     = 1;
    localparam int CTRL_LOOP     = 2;
    localparam int CTRL_CLR_COLL = 3;
    localparam int CTRL_CLR_DONE = 4;

    localparam int STAT_BUSY = 0;
    localparam int STAT_COLL = 1;
    localparam int STAT_DONE = 2;
    localparam int STAT_LOOP = 3;

    localparam logic [2:0] WORD_CONFIG  = 3'd0;
    localparam logic [2:0] WORD_DATA_LO = 3'd1;
    localparam logic [2:0] WORD_DATA_HI = 3'd2;
    localparam logic [2:0] WORD_SEL     = 3'd3;
    localparam logic [2:0] WORD_DELAY   = 3'd4;

    localparam logic [1:0] PWM_REG_CONFIG  = 2'd0;
    localparam logic [1:0] PWM_REG_DATA_LO = 2'd1;
    localparam logic [1:0] PWM_REG_DATA_HI = 2'd2;
    localparam logic [1:0] PWM_REG_SEL     = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WR_CFG = 3'd2,
        ST_WR_LO  = 3'd3,
        ST_WR_HI  = 3'd4,
        ST_WR_SEL = 3'd5,
        ST_WAIT   = 3'd6
    } seq_state_e;

    // Word addressed in this state, so that it sits on the read port in the next state.
    function automatic logic [2:0] read_word(input seq_state_e st);
        case (st)
            ST_WR_CFG: read_word = WORD_DATA_LO;
            ST_WR_LO:  read_word = WORD_DATA_HI;
            ST_WR_HI:  read_word = WORD_SEL;
            ST_WR_SEL: read_word = WORD_DELAY;
            default:   read_word = WORD_CONFIG;
        endcase
    endfunction

    function automatic logic [1:0] pwm_reg(input seq_state_e st);
        case (st)
            ST_WR_LO:  pwm_reg = PWM_REG_DATA_LO;
            ST_WR_HI:  pwm_reg = PWM_REG_DATA_HI;
            ST_WR_SEL: pwm_reg = PWM_REG_SEL;
            default:   pwm_reg = PWM_REG_CONFIG;
        endcase
    endfunction

    function automatic logic is_locked(input seq_state_e st);
        case (st)
            ST_WR_CFG, ST_WR_LO, ST_WR_HI, ST_WR_SEL: is_locked = 1'b1;
            default:                                  is_locked = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/spmc_pwm_seq_table.sv
// Sequencer table RAM: one CPU write port, one synchronous FSM read port.
// Contents are deliberately not reset.
module spmc_pwm_seq_table #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 18
) (
    input  logic                          clk_i,
    input  logic                          we_i,
    input  logic [$clog2(DEPTH*8)-1:0]    waddr_i,
    input  logic [DATA_W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH*8)-1:0]    raddr_i,
    output logic [DATA_W-1:0]             rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH*8];
    logic [DATA_W-1:0] rdata_q;

    // Write port and registered read port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spmc_pwm_sequencer.sv
// Table-driven PWM update sequencer and bus arbiter in front of spmc_pwm.
// Replays 4-write transactions that are never interleaved with CPU writes to the PWM.
module spmc_pwm_sequencer
    import spmc_pwm_sequencer_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADR    = 10'h0,
    parameter logic [ADDR_W-1:0] PWM_BASE    = 10'h0,
    parameter int                DEPTH       = 16,
    parameter int                PRESC_WIDTH = 18
) (
    input  logic              clk_peri,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] do_peri,
    output logic [DATA_W-1:0] di_peri,
    input  logic [ADDR_W-1:0] addr_peri,
    input  logic              access_peri,
    input  logic              wr_peri,
    output logic [DATA_W-1:0] pwm_do_peri,
    output logic [ADDR_W-1:0] pwm_addr_peri,
    output logic              pwm_access_peri,
    output logic              pwm_wr_peri,
    output logic              busy,
    output logic              done_irq
);

    localparam int ENTRY_W = $clog2(DEPTH);
    localparam int LEN_W   = ENTRY_W + 1;
    localparam int IDX_W   = ENTRY_W + 3;

    seq_state_e             state_q, state_d, adv_state_s;
    logic [ENTRY_W-1:0]     entry_q, entry_d, adv_entry_s;
    logic                   stop_pend_q, stop_pend_d;
    logic                   wait_load_q, wait_load_d;
    logic [DATA_W-1:0]      delay_cnt_q, delay_cnt_d;
    logic [PRESC_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic [IDX_W-1:0]       tbl_idx_q, tbl_idx_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic                   loop_q, loop_d, done_q, done_d, coll_q, coll_d, done_irq_q;
    logic [DATA_W-1:0]      rd_data_s, tbl_rdata_s;
    logic [IDX_W-1:0]       tbl_raddr_s;
    logic                   sel_s, cpu_wr_s, cpu_rd_s, ctrl_wr_s, start_s, stop_s, tbl_wr_s;
    logic                   locked_s, in_pwm_s, coll_set_s, done_set_s, adv_done_s, last_s;

    assign sel_s      = (addr_peri[ADDR_W-1:3] == BASE_ADR[ADDR_W-1:3]);
    assign cpu_wr_s   = sel_s & access_peri & wr_peri;
    assign cpu_rd_s   = sel_s & access_peri & ~wr_peri;
    assign ctrl_wr_s  = cpu_wr_s & (addr_peri[2:0] == REG_CTRL);
    assign start_s    = ctrl_wr_s & do_peri[CTRL_START];
    assign stop_s     = ctrl_wr_s & do_peri[CTRL_STOP];
    assign tbl_wr_s   = cpu_wr_s & (addr_peri[2:0] == REG_TBL_DATA) & (state_q == ST_IDLE);
    assign locked_s   = is_locked(state_q);
    assign in_pwm_s   = (addr_peri[ADDR_W-1:2] == PWM_BASE[ADDR_W-1:2]);
    assign coll_set_s = locked_s & access_peri & wr_peri & in_pwm_s;
    assign last_s     = (({1'b0, entry_q} + LEN_W'(1)) >= len_q);
    assign tbl_raddr_s = {entry_q, read_word(state_q)};

    spmc_pwm_seq_table #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_table (
        .clk_i   (clk_peri),
        .we_i    (tbl_wr_s),
        .waddr_i (tbl_idx_q),
        .wdata_i (do_peri),
        .raddr_i (tbl_raddr_s),
        .rdata_o (tbl_rdata_s)
    );

    // Successor once the current entry's delay has elapsed.
    always_comb begin
        adv_state_s = ST_FETCH;
        adv_entry_s = '0;
        adv_done_s  = 1'b0;
        if (!last_s) begin
            adv_entry_s = entry_q + ENTRY_W'(1);
        end else if (loop_q) begin
            adv_entry_s = '0;
        end else begin
            adv_entry_s = entry_q;
            adv_state_s = ST_IDLE;
            adv_done_s  = 1'b1;
        end
    end

    // Sequencer next-state logic.
    always_comb begin
        state_d     = state_q;
        entry_d     = entry_q;
        stop_pend_d = stop_pend_q;
        wait_load_d = wait_load_q;
        delay_cnt_d = delay_cnt_q;
        presc_cnt_d = presc_cnt_q;
        done_set_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stop_pend_d = 1'b0;
                if (start_s && (len_q != '0)) begin
                    entry_d = '0;
                    state_d = ST_FETCH;
                end else if (start_s) begin
                    done_set_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (stop_s) state_d = ST_IDLE;
                else        state_d = ST_WR_CFG;
            end
            // STOP inside a transaction is only remembered; the transaction always finishes.
            ST_WR_CFG: begin
                stop_pend_d = stop_pend_q | stop_s;
                state_d     = ST_WR_LO;
            end
            ST_WR_LO: begin
                stop_pend_d = stop_pend_q | stop_s;
                state_d     = ST_WR_HI;
            end
            ST_WR_HI: begin
                stop_pend_d = stop_pend_q | stop_s;
                state_d     = ST_WR_SEL;
            end
            ST_WR_SEL: begin
                stop_pend_d = 1'b0;
                if (stop_pend_q || stop_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d     = ST_WAIT;
                    wait_load_d = 1'b1;
                end
            end
            ST_WAIT: begin
                wait_load_d = 1'b0;
                if (stop_s) begin
                    state_d = ST_IDLE;
                end else if (wait_load_q && (tbl_rdata_s == '0)) begin
                    state_d    = adv_state_s;
                    entry_d    = adv_entry_s;
                    done_set_s = adv_done_s;
                end else if (wait_load_q) begin
                    delay_cnt_d = tbl_rdata_s;
                    presc_cnt_d = presc_q;
                end else if (presc_cnt_q != '0) begin
                    presc_cnt_d = presc_cnt_q - PRESC_WIDTH'(1);
                end else if (delay_cnt_q == DATA_W'(1)) begin
                    state_d    = adv_state_s;
                    entry_d    = adv_entry_s;
                    done_set_s = adv_done_s;
                end else begin
                    delay_cnt_d = delay_cnt_q - DATA_W'(1);
                    presc_cnt_d = presc_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // CPU-visible register updates.
    always_comb begin
        loop_d    = loop_q;
        coll_d    = coll_q;
        done_d    = done_q;
        tbl_idx_d = tbl_idx_q;
        len_d     = len_q;
        presc_d   = presc_q;
        if (ctrl_wr_s) loop_d = do_peri[CTRL_LOOP];
        else           loop_d = loop_q;
        if (coll_set_s)                             coll_d = 1'b1;
        else if (ctrl_wr_s && do_peri[CTRL_CLR_COLL]) coll_d = 1'b0;
        else                                        coll_d = coll_q;
        if (done_set_s)                             done_d = 1'b1;
        else if (ctrl_wr_s && do_peri[CTRL_CLR_DONE]) done_d = 1'b0;
        else                                        done_d = done_q;
        if (cpu_wr_s && (addr_peri[2:0] == REG_TBL_IDX)) tbl_idx_d = do_peri[IDX_W-1:0];
        else if (tbl_wr_s)                               tbl_idx_d = tbl_idx_q + IDX_W'(1);
        else                                             tbl_idx_d = tbl_idx_q;
        if (cpu_wr_s && (addr_peri[2:0] == REG_LEN)) begin
            if (do_peri > DATA_W'(DEPTH)) len_d = LEN_W'(DEPTH);
            else                          len_d = do_peri[LEN_W-1:0];
        end else begin
            len_d = len_q;
        end
        if (cpu_wr_s && (addr_peri[2:0] == REG_PRESC)) presc_d = do_peri[PRESC_WIDTH-1:0];
        else                                           presc_d = presc_q;
    end

    // Read-back mux; zero whenever this block is not being read.
    always_comb begin
        rd_data_s = '0;
        if (cpu_rd_s) begin
            case (addr_peri[2:0])
                REG_CTRL: begin
                    rd_data_s[STAT_BUSY] = (state_q != ST_IDLE);
                    rd_data_s[STAT_COLL] = coll_q;
                    rd_data_s[STAT_DONE] = done_q;
                    rd_data_s[STAT_LOOP] = loop_q;
                end
                REG_TBL_IDX: rd_data_s = DATA_W'(tbl_idx_q);
                REG_LEN:     rd_data_s = DATA_W'(len_q);
                REG_PRESC:   rd_data_s = DATA_W'(presc_q);
                default:     rd_data_s = '0;
            endcase
        end else begin
            rd_data_s = '0;
        end
    end

    // Downstream bus: sequencer owns it during WR_*, otherwise the CPU passes straight through.
    always_comb begin
        if (locked_s) begin
            pwm_do_peri     = tbl_rdata_s;
            pwm_addr_peri   = {PWM_BASE[ADDR_W-1:2], pwm_reg(state_q)};
            pwm_access_peri = 1'b1;
            pwm_wr_peri     = 1'b1;
        end else begin
            pwm_do_peri     = do_peri;
            pwm_addr_peri   = addr_peri;
            pwm_access_peri = access_peri;
            pwm_wr_peri     = wr_peri;
        end
    end

    // State and register file.
    always_ff @(posedge clk_peri or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            entry_q     <= '0;
            stop_pend_q <= 1'b0;
            wait_load_q <= 1'b0;
            delay_cnt_q <= '0;
            presc_cnt_q <= '0;
            presc_q     <= '0;
            tbl_idx_q   <= '0;
            len_q       <= '0;
            loop_q      <= 1'b0;
            done_q      <= 1'b0;
            coll_q      <= 1'b0;
            done_irq_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            stop_pend_q <= stop_pend_d;
            wait_load_q <= wait_load_d;
            delay_cnt_q <= delay_cnt_d;
            presc_cnt_q <= presc_cnt_d;
            presc_q     <= presc_d;
            tbl_idx_q   <= tbl_idx_d;
            len_q       <= len_d;
            loop_q      <= loop_d;
            done_q      <= done_d;
            coll_q      <= coll_d;
            done_irq_q  <= done_set_s;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done_irq = done_irq_q;
    assign di_peri  = rd_data_s;

endmodule

// File: tb/tb_spmc_pwm_sequencer.sv
// Directed bench for spmc_pwm_sequencer: cycle-exact PWM write timing, loop/stop,
// collision arbitration, empty-table start and asynchronous reset.
module tb_spmc_pwm_sequencer;

    localparam logic [9:0] BASE   = 10'h100;
    localparam logic [9:0] PWMB   = 10'h040;
    localparam logic [9:0] A_CTRL = BASE + 10'd0;
    localparam logic [9:0] A_IDX  = BASE + 10'd1;
    localparam logic [9:0] A_DATA = BASE + 10'd2;
    localparam logic [9:0] A_LEN  = BASE + 10'd3;
    localparam logic [9:0] A_PRE  = BASE + 10'd4;
    localparam logic [9:0] A_R5   = BASE + 10'd5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [17:0] do_s = 18'd0;
    logic [9:0]  addr_s = 10'd0;
    logic        acc_s = 1'b0;
    logic        wr_s = 1'b0;
    logic [17:0] di_s, pwm_do_s;
    logic [9:0]  pwm_addr_s;
    logic        pwm_acc_s, pwm_wr_s, busy_s, irq_s;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int s;
    logic [17:0] rd;

    int          log_cyc[$];
    logic [9:0]  log_adr[$];
    logic [17:0] log_dat[$];
    int          irq_cyc[$];

    spmc_pwm_sequencer #(
        .BASE_ADR    (BASE),
        .PWM_BASE    (PWMB),
        .DEPTH       (4),
        .PRESC_WIDTH (18)
    ) dut (
        .clk_peri        (clk),
        .reset_n         (rst_n),
        .do_peri         (do_s),
        .di_peri         (di_s),
        .addr_peri       (addr_s),
        .access_peri     (acc_s),
        .wr_peri         (wr_s),
        .pwm_do_peri     (pwm_do_s),
        .pwm_addr_peri   (pwm_addr_s),
        .pwm_access_peri (pwm_acc_s),
        .pwm_wr_peri     (pwm_wr_s),
        .busy            (busy_s),
        .done_irq        (irq_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write reaching the PWM window and every done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && pwm_acc_s && pwm_wr_s && (pwm_addr_s >= PWMB) && (pwm_addr_s <= PWMB + 10'd3)) begin
            log_cyc.push_back(cyc);
            log_adr.push_back(pwm_addr_s);
            log_dat.push_back(pwm_do_s);
        end
        if (irq_s) irq_cyc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [9:0] a, input logic [17:0] d);
        acc_s = 1'b1; wr_s = 1'b1; addr_s = a; do_s = d;
        @(posedge clk); #1;
        acc_s = 1'b0; wr_s = 1'b0; addr_s = 10'd0; do_s = 18'd0;
    endtask

    task automatic bus_rd(input logic [9:0] a, output logic [17:0] d);
        acc_s = 1'b1; wr_s = 1'b0; addr_s = a;
        #2 d = di_s;
        @(posedge clk); #1;
        acc_s = 1'b0; addr_s = 10'd0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_s && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, {31'd0, busy_s}, 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic load_entry(input int e, input logic [17:0] w0, input logic [17:0] w1,
                              input logic [17:0] w2, input logic [17:0] w3, input logic [17:0] w4);
        bus_wr(A_IDX, 18'(e * 8));
        bus_wr(A_DATA, w0);
        bus_wr(A_DATA, w1);
        bus_wr(A_DATA, w2);
        bus_wr(A_DATA, w3);
        bus_wr(A_DATA, w4);
    endtask

    task automatic clear_logs();
        log_cyc.delete(); log_adr.delete(); log_dat.delete(); irq_cyc.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy_s}, 32'd0);
        chk("rst_irq", {31'd0, irq_s}, 32'd0);
        chk("rst_di", 32'(di_s), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // pass-through after reset
        acc_s = 1'b1; wr_s = 1'b1; addr_s = PWMB + 10'd1; do_s = 18'h01234;
        #1;
        chk("pt_addr", 32'(pwm_addr_s), 32'h041);
        chk("pt_do", 32'(pwm_do_s), 32'h01234);
        chk("pt_acc_wr", {30'd0, pwm_acc_s, pwm_wr_s}, 32'd3);
        acc_s = 1'b0; wr_s = 1'b0; addr_s = 10'd0; do_s = 18'd0;
        @(posedge clk); #1;
        bus_rd(A_CTRL, rd); chk("rst_ctrl", 32'(rd), 32'd0);
        bus_rd(A_LEN, rd);  chk("rst_len", 32'(rd), 32'd0);

        // register boundaries
        bus_wr(A_LEN, 18'h0003F);
        bus_rd(A_LEN, rd);  chk("len_sat", 32'(rd), 32'd4);
        bus_wr(A_IDX, 18'd31);
        bus_wr(A_DATA, 18'h3FFFF);
        bus_rd(A_IDX, rd);  chk("idx_wrap", 32'(rd), 32'd0);
        bus_rd(A_DATA, rd); chk("data_rd0", 32'(rd), 32'd0);
        bus_wr(A_R5, 18'h3FFFF);
        bus_rd(A_R5, rd);   chk("reg5_rd0", 32'(rd), 32'd0);

        // test 1: single entry, no delay
        load_entry(0, 18'h0, 18'h00100, 18'h0, 18'h1, 18'h0);
        bus_wr(A_LEN, 18'd1);
        bus_wr(A_PRE, 18'd0);
        clear_logs();
        s = cyc;
        bus_wr(A_CTRL, 18'h1);
        wait_idle("t1_idle");
        chk("t1_nwr", 32'(log_cyc.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_cyc", 32'(log_cyc[i] - s), 32'(2 + i));
            chk("t1_adr", 32'(log_adr[i]), 32'(PWMB) + 32'(i));
        end
        chk("t1_w1", 32'(log_dat[1]), 32'h100);
        chk("t1_w3", 32'(log_dat[3]), 32'h1);
        chk("t1_nirq", 32'(irq_cyc.size()), 32'd1);
        chk("t1_irq_cyc", 32'(irq_cyc[0] - s), 32'd7);
        bus_rd(A_CTRL, rd); chk("t1_status", 32'(rd), 32'h4);

        // test 2: prescaled delay between entries
        load_entry(0, 18'h1, 18'h10, 18'h20, 18'h1, 18'd2);
        load_entry(1, 18'h2, 18'h30, 18'h40, 18'h3, 18'd0);
        bus_wr(A_LEN, 18'd2);
        bus_wr(A_PRE, 18'd3);
        bus_rd(A_PRE, rd); chk("t2_presc", 32'(rd), 32'd3);
        bus_wr(A_CTRL, 18'h10);
        clear_logs();
        s = cyc;
        bus_wr(A_CTRL, 18'h1);
        wait_idle("t2_idle");
        chk("t2_nwr", 32'(log_cyc.size()), 32'd8);
        chk("t2_cfg0", 32'(log_cyc[0] - s), 32'd2);
        chk("t2_cfg1", 32'(log_cyc[4] - s), 32'd16);
        chk("t2_cfg1_dat", 32'(log_dat[4]), 32'h2);
        chk("t2_irq_cyc", 32'(irq_cyc[0] - s), 32'd21);

        // test 3: looping run stopped inside a transaction
        load_entry(0, 18'h5, 18'h11, 18'h22, 18'h1, 18'd0);
        bus_wr(A_PRE, 18'd0);
        bus_wr(A_CTRL, 18'h10);
        clear_logs();
        s = cyc;
        bus_wr(A_CTRL, 18'h5);
        wait_cyc(s + 21);
        bus_wr(A_CTRL, 18'h6);
        wait_idle("t3_idle");
        chk("t3_nwr", 32'(log_cyc.size()), 32'd16);
        chk("t3_p1_cfg", 32'(log_cyc[4] - s), 32'd8);
        chk("t3_p3_entry", 32'(log_dat[12]), 32'h2);
        chk("t3_last_cyc", 32'(log_cyc[15] - s), 32'd23);
        chk("t3_last_adr", 32'(log_adr[15]), 32'(PWMB) + 32'd3);
        chk("t3_nirq", 32'(irq_cyc.size()), 32'd0);
        bus_rd(A_CTRL, rd); chk("t3_status", 32'(rd), 32'h8);

        // test 4: CPU collision during WR_HI, forwarded write during WAIT
        load_entry(0, 18'h3, 18'h155, 18'h2F0F0, 18'h2, 18'd3);
        bus_wr(A_LEN, 18'd1);
        bus_wr(A_CTRL, 18'h18);
        clear_logs();
        s = cyc;
        bus_wr(A_CTRL, 18'h1);
        wait_cyc(s + 4);
        bus_wr(PWMB + 10'd1, 18'h2AAAA);
        wait_cyc(s + 7);
        bus_wr(PWMB + 10'd1, 18'h2AAAA);
        wait_idle("t4_idle");
        chk("t4_nwr", 32'(log_cyc.size()), 32'd5);
        chk("t4_hi_adr", 32'(log_adr[2]), 32'(PWMB) + 32'd2);
        chk("t4_hi_dat", 32'(log_dat[2]), 32'h2F0F0);
        chk("t4_fwd_cyc", 32'(log_cyc[4] - s), 32'd7);
        chk("t4_fwd_adr", 32'(log_adr[4]), 32'(PWMB) + 32'd1);
        chk("t4_fwd_dat", 32'(log_dat[4]), 32'h2AAAA);
        bus_rd(A_CTRL, rd); chk("t4_status", 32'(rd), 32'h6);

        // test 5a: empty table
        bus_wr(A_CTRL, 18'h18);
        bus_wr(A_LEN, 18'd0);
        clear_logs();
        s = cyc;
        bus_wr(A_CTRL, 18'h1);
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("t5_nwr", 32'(log_cyc.size()), 32'd0);
        chk("t5_irq_cyc", 32'(irq_cyc[0] - s), 32'd1);
        bus_rd(A_CTRL, rd); chk("t5_status", 32'(rd), 32'h4);

        // test 5b: START while busy is ignored
        bus_wr(A_CTRL, 18'h10);
        bus_wr(A_LEN, 18'd1);
        clear_logs();
        s = cyc;
        bus_wr(A_CTRL, 18'h1);
        wait_cyc(s + 3);
        bus_wr(A_CTRL, 18'h1);
        wait_idle("t5b_idle");
        chk("t5b_nwr", 32'(log_cyc.size()), 32'd4);
        chk("t5b_nirq", 32'(irq_cyc.size()), 32'd1);
        chk("t5b_irq_cyc", 32'(irq_cyc[0] - s), 32'd10);

        // test 6: asynchronous reset during WR_LO
        s = cyc;
        bus_wr(A_CTRL, 18'h1);
        wait_cyc(s + 3);
        chk("t6_locked", 32'(pwm_addr_s), 32'(PWMB) + 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_acc", {30'd0, pwm_acc_s, pwm_wr_s}, 32'd0);
        chk("t6_addr", 32'(pwm_addr_s), 32'd0);
        chk("t6_do", 32'(pwm_do_s), 32'd0);
        chk("t6_busy", {30'd0, busy_s, irq_s}, 32'd0);
        chk("t6_di", 32'(di_s), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        acc_s = 1'b1; wr_s = 1'b0; addr_s = PWMB + 10'd3;
        #1;
        chk("t6_pt_addr", 32'(pwm_addr_s), 32'(PWMB) + 32'd3);
        chk("t6_pt_acc_wr", {30'd0, pwm_acc_s, pwm_wr_s}, 32'd2);
        acc_s = 1'b0; addr_s = 10'd0;
        @(posedge clk); #1;
        bus_rd(A_LEN, rd);  chk("t6_len", 32'(rd), 32'd0);
        bus_rd(A_CTRL, rd); chk("t6_ctrl", 32'(rd), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
